muldiv_unit: RTL and testbench

Iterative multiply/divide engine that produces the HI/LO result pair for MULT/MULTU/DIV/DIVU. It sits beside the execute stage. It accepts one operation via a start/busy handshake, computes over multiple cycles, and presents the 64-bit result as muldiv_hi/muldiv_lo together with a one-cycle write strobe. The pipeline carries that strobe to the HI/LO register write enable.

---
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / restoring divide engine producing the HI/LO pair.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply for MULT/MULTU (2-cycle latency).
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic        muldiv_we,
  output logic [31:0] muldiv_hi,
  output logic [31:0] muldiv_lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, SIGN = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [63:0] acc_reg, acc_next;
  logic [31:0] m_reg, m_next;
  logic        is_div_reg, is_div_next;
  logic        sign_diff_reg, sign_diff_next;
  logic        a_neg_reg, a_neg_next;
  logic        div0_reg, div0_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;

  logic        is_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, div_trial;
  logic [63:0] mul_step, div_step, neg_acc;
  logic [31:0] quot, rem;

  // MULT and DIV are the signed ops (op[0]=0); |0x80000000| is read as unsigned 2^31
  assign is_signed = ~op[0];
  assign abs_a     = (is_signed && operand_a[31]) ? (32'd0 - operand_a) : operand_a;
  assign abs_b     = (is_signed && operand_b[31]) ? (32'd0 - operand_b) : operand_b;

  assign mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, m_reg} : 33'd0);
  assign mul_step  = {mul_sum, acc_reg[31:1]};
  assign div_trial = acc_reg[63:31] - {1'b0, m_reg};
  assign div_step  = div_trial[32] ? {acc_reg[62:0], 1'b0}
                                   : {div_trial[31:0], acc_reg[30:0], 1'b1};

  // Remainder takes the dividend's sign, which also makes a divide-by-zero hi equal operand_a
  assign neg_acc   = 64'd0 - acc_reg;
  assign quot      = div0_reg ? 32'hFFFF_FFFF
                              : (sign_diff_reg ? neg_acc[31:0] : acc_reg[31:0]);
  assign rem       = a_neg_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 5'd0;
      acc_reg       <= 64'd0;
      m_reg         <= 32'd0;
      is_div_reg    <= 1'b0;
      sign_diff_reg <= 1'b0;
      a_neg_reg     <= 1'b0;
      div0_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      hi_reg        <= 32'd0;
      lo_reg        <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      m_reg         <= m_next;
      is_div_reg    <= is_div_next;
      sign_diff_reg <= sign_diff_next;
      a_neg_reg     <= a_neg_next;
      div0_reg      <= div0_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start && !cancel) begin
`ifdef MULDIV_FAST_MUL_EN
          state_next = op[1] ? CALC : SIGN;
`else
          state_next = CALC;
`endif
        end
      end
      CALC: begin
        if (cancel)                state_next = IDLE;
        else if (cnt_reg == 5'd31) state_next = SIGN;
      end
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    m_next         = m_reg;
    is_div_next    = is_div_reg;
    sign_diff_next = sign_diff_reg;
    a_neg_next     = a_neg_reg;
    div0_next      = div0_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    done_next      = 1'b0;
    busy_next      = (state_next != IDLE);
    case (state_reg)
      IDLE: begin
        if (start && !cancel) begin
          cnt_next       = 5'd0;
          is_div_next    = op[1];
          sign_diff_next = is_signed & (operand_a[31] ^ operand_b[31]);
          a_neg_next     = is_signed & operand_a[31];
          div0_next      = op[1] && (operand_b == 32'd0);
          if (op[1]) begin
            m_next   = abs_b;
            acc_next = {32'd0, abs_a};
          end else begin
            m_next   = abs_a;
`ifdef MULDIV_FAST_MUL_EN
            acc_next = 64'(abs_a) * 64'(abs_b);
`else
            acc_next = {32'd0, abs_b};
`endif
          end
        end
      end
      CALC: begin
        cnt_next = cnt_reg + 5'd1;
        acc_next = is_div_reg ? div_step : mul_step;
      end
      SIGN: begin
        if (!cancel) begin
          done_next = 1'b1;
          if (is_div_reg) begin
            hi_next = rem;
            lo_next = quot;
          end else if (sign_diff_reg) begin
            hi_next = neg_acc[63:32];
            lo_next = neg_acc[31:0];
          end else begin
            hi_next = acc_reg[63:32];
            lo_next = acc_reg[31:0];
          end
        end
      end
      default: ;
    endcase
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign muldiv_we = done_reg;
  assign muldiv_hi = hi_reg;
  assign muldiv_lo = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: result table plus control corner sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic        muldiv_we;
  logic [31:0] muldiv_hi;
  logic [31:0] muldiv_lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .muldiv_we (muldiv_we),
    .muldiv_hi (muldiv_hi),
    .muldiv_lo (muldiv_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Edges after the start-sampling edge until done appears
  function automatic int exp_edges(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
    return o[1] ? 33 : 1;
`else
    return 33;
`endif
  endfunction

  // Entered and left at #1 after a rising edge; leaves in the done cycle
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    bit dropped;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0; dropped = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!done && !busy) dropped = 1;
    end while (!done && n < 80);
    chk("latency", n, exp_edges(o));
    chk("busy_held", dropped, 0);
    chk("we_eq_done", muldiv_we, 1);
    chk("busy_in_done", busy, 0);
    chk("hi", muldiv_hi, ehi);
    chk("lo", muldiv_lo, elo);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h edges=%0d", o, a, b, muldiv_hi, muldiv_lo, n);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done || muldiv_we) cnt++;
    end
  endtask

  initial begin
    int n;
    int cnt;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{2'b11, 32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF};
    vecs[6]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[7]  = '{2'b00, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[9]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[10] = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[11] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};

    rst = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00;
    operand_a = 32'd0; operand_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", muldiv_we, 0);
    chk("rst_hilo", {muldiv_hi, muldiv_lo}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
      @(posedge clk); #1;
      chk("done_width", {done, muldiv_we}, 2'b00);
    end

    // Back-to-back: next start issued in the done cycle
    do_op(2'b11, 32'd10, 32'd3, 32'd1, 32'd3);
    do_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
    @(posedge clk); #1;

    // Second start pulse at edge 5 is ignored
    start = 1'b1; op = 2'b11; operand_a = 32'd10; operand_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b01; operand_a = 32'd5; operand_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    n = 5;
    while (!done && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ignored_start_latency", n, 33);
    chk("ignored_start_hilo", {muldiv_hi, muldiv_lo}, {32'd1, 32'd3});
    $display("ignored-start seq -> hi=%h lo=%h edges=%0d", muldiv_hi, muldiv_lo, n);
    count_done(40, cnt);
    chk("ignored_start_single_done", cnt, 0);

    // Cancel raised after edge 10, sampled at edge 11
    start = 1'b1; op = 2'b01; operand_a = 32'd5; operand_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_busy", busy, 0);
    chk("cancel_done", done, 0);
    count_done(40, cnt);
    chk("cancel_no_done", cnt, 0);
    chk("cancel_hilo_kept", {muldiv_hi, muldiv_lo}, {32'd1, 32'd3});
    $display("cancel seq -> busy=%0d hi=%h lo=%h", busy, muldiv_hi, muldiv_lo);

    // Cancel together with start in IDLE drops the start
    start = 1'b1; cancel = 1'b1; op = 2'b00; operand_a = 32'd2; operand_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_busy", busy, 0);
    count_done(40, cnt);
    chk("cancel_start_no_done", cnt, 0);
    $display("cancel+start seq -> busy=%0d", busy);

    // Reset sampled at edge 20 of a MULTU
    start = 1'b1; op = 2'b01; operand_a = 32'd5; operand_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", {done, muldiv_we}, 2'b00);
    chk("midrst_hilo", {muldiv_hi, muldiv_lo}, 64'd0);
    count_done(40, cnt);
    chk("midrst_no_done", cnt, 0);
    $display("reset seq -> busy=%0d hi=%h lo=%h", busy, muldiv_hi, muldiv_lo);

    do_op(2'b01, 32'd5, 32'd7, 32'd0, 32'd35);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
